// File: rtl/types_pkg.sv
// Shared types for the MINAv2 pipeline control logic.
//   fw_sel_e     : operand forwarding select driven to the EX stage
//   pipe_state_e : memory-wait sequencing state of pipe_ctrl
//   dest_match() : destination/source register match with optional r0 exclusion
package types;

    // The EX/MEM and MEM/WB encodings are pre-existing; NONE uses the spare zero code.
    typedef enum logic [1:0] {
        FW_SEL_NONE   = 2'b00,
        FW_SEL_EX_MEM = 2'b01,
        FW_SEL_MEM_WB = 2'b10
    } fw_sel_e;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT    = 2'b01,
        TIMEOUT = 2'b10
    } pipe_state_e;

    localparam int WAIT_CNT_W = 16;

    // Addresses are zero-extended to 32 bits by the caller so one function
    // serves any register address width.
    function automatic logic dest_match(
        input logic        we,
        input logic [31:0] rd_addr,
        input logic [31:0] rs_addr,
        input logic        zero_reg
    );
        return we && (rd_addr == rs_addr) && !(zero_reg && (rd_addr == 32'd0));
    endfunction

endpackage

// File: rtl/pipe_ctrl_fw_select.sv
// fw_select: combinational forwarding select for one EX-stage source operand.
//   src_addr              : source register of the instruction in EX
//   mem_rd_addr/mem_rd_we : EX/MEM destination (youngest, highest priority)
//   wb_rd_addr/wb_rd_we   : MEM/WB destination
//   sel                   : chosen forwarding path
module fw_select
    import types::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_we,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_we,
    output fw_sel_e               sel
);

    always_comb begin
        sel = FW_SEL_NONE;
        if (dest_match(mem_rd_we, 32'(mem_rd_addr), 32'(src_addr), ZERO_REG)) begin
            sel = FW_SEL_EX_MEM;
        end else if (dest_match(wb_rd_we, 32'(wb_rd_addr), 32'(src_addr), ZERO_REG)) begin
            sel = FW_SEL_MEM_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller beside the EX stage.
//   Inputs : ID/EX source addresses and use flags, EX/MEM/WB destinations,
//            branch_req from EX, mem_req/mem_ready data-memory handshake.
//   Outputs: ra_sel/rb_sel forwarding selects, per-register stalls, load
//            bubble flushes, pc_load_branch, sticky mem_timeout watchdog
//            flag and a saturating stall_cycles counter.
// All control outputs are combinational; only mem_timeout and stall_cycles
// are registered.
module pipe_ctrl
    import types::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter bit ZERO_REG    = 1'b1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_ra_addr,
    input  logic [REG_ADDR_W-1:0] id_rb_addr,
    input  logic                  id_ra_used,
    input  logic                  id_rb_used,
    input  logic [REG_ADDR_W-1:0] ex_ra_addr,
    input  logic [REG_ADDR_W-1:0] ex_rb_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_we,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_rd_we,
    input  logic                  branch_req,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output fw_sel_e               ra_sel,
    output fw_sel_e               rb_sel,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  pc_load_branch,
    output logic                  mem_timeout,
    output logic [31:0]           stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

    fw_sel_e ra_fw, rb_fw;

    fw_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fw_ra (
        .src_addr    (ex_ra_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_we   (mem_rd_we),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .sel         (ra_fw)
    );

    fw_select #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_fw_rb (
        .src_addr    (ex_rb_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_we   (mem_rd_we),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .sel         (rb_fw)
    );

    // Hazard detection
    logic freeze, load_use, count_stall;

    assign freeze   = mem_req && !mem_ready;
    assign load_use = ex_is_load &&
        ((id_ra_used && dest_match(ex_rd_we, 32'(ex_rd_addr), 32'(id_ra_addr), ZERO_REG)) ||
         (id_rb_used && dest_match(ex_rd_we, 32'(ex_rd_addr), 32'(id_rb_addr), ZERO_REG)));
    // A load-use bubble squashed by a branch never happens, so it is not counted.
    assign count_stall = freeze || (load_use && !branch_req);

    // State register
    pipe_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [31:0]           stall_cycles_q, stall_cycles_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Next-state logic. The first freeze cycle already counts as wait cycle 1,
    // so the counter is loaded with 1 on the RUN->WAIT transition.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    wait_cnt_d = WAIT_CNT_W'(1);
                    state_d    = (wait_cnt_d >= TIMEOUT_LIM) ? TIMEOUT : WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                    if (wait_cnt_d >= TIMEOUT_LIM) begin
                        state_d = TIMEOUT;
                    end
                end
            end
            TIMEOUT: begin
                // Counter holds its value here; it only clears back in RUN.
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        mem_timeout_d  = mem_timeout_q || (state_d == TIMEOUT);
        stall_cycles_d = (count_stall && (stall_cycles_q != 32'hFFFF_FFFF))
                         ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    // Output logic, priority rst > freeze > branch_req > load_use.
    always_comb begin
        ra_sel         = ra_fw;
        rb_sel         = rb_fw;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_stall   = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        pc_load_branch = 1'b0;
        if (rst) begin
            ra_sel      = FW_SEL_NONE;
            rb_sel      = FW_SEL_NONE;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (freeze) begin
            // A pending branch stays held in the frozen ID/EX and fires on release.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (branch_req) begin
            pc_load_branch = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import types::*;

    logic       clk;
    logic       rst;
    logic [4:0] id_ra_addr, id_rb_addr, ex_ra_addr, ex_rb_addr, ex_rd_addr;
    logic [4:0] mem_rd_addr, wb_rd_addr;
    logic       id_ra_used, id_rb_used, ex_rd_we, ex_is_load, mem_rd_we, wb_rd_we;
    logic       branch_req, mem_req, mem_ready;
    fw_sel_e    ra_sel, rb_sel;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic       if_id_flush, id_ex_flush, pc_load_branch, mem_timeout;
    logic [31:0] stall_cycles;

    int n_chk = 0;
    int n_bad = 0;

    pipe_ctrl #(.REG_ADDR_W(5), .ZERO_REG(1'b1), .MEM_TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_ra_addr     (id_ra_addr),
        .id_rb_addr     (id_rb_addr),
        .id_ra_used     (id_ra_used),
        .id_rb_used     (id_rb_used),
        .ex_ra_addr     (ex_ra_addr),
        .ex_rb_addr     (ex_rb_addr),
        .ex_rd_addr     (ex_rd_addr),
        .ex_rd_we       (ex_rd_we),
        .ex_is_load     (ex_is_load),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_we      (mem_rd_we),
        .wb_rd_addr     (wb_rd_addr),
        .wb_rd_we       (wb_rd_we),
        .branch_req     (branch_req),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .ra_sel         (ra_sel),
        .rb_sel         (rb_sel),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .id_ex_stall    (id_ex_stall),
        .ex_mem_stall   (ex_mem_stall),
        .mem_wb_stall   (mem_wb_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .pc_load_branch (pc_load_branch),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_ra_addr = '0; id_rb_addr = '0; id_ra_used = 0; id_rb_used = 0;
        ex_ra_addr = 5'd3; ex_rb_addr = '0; ex_rd_addr = '0; ex_rd_we = 0; ex_is_load = 0;
        mem_rd_addr = 5'd3; mem_rd_we = 1; wb_rd_addr = '0; wb_rd_we = 0;
        branch_req = 0; mem_req = 0; mem_ready = 0;
        #1;
        // Reset: flushes high, no stalls, selects forced to NONE
        chk("rst_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("rst_pc_stall", 32'(pc_stall), 32'd0);
        chk("rst_ra_sel", 32'(ra_sel), 32'(FW_SEL_NONE));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("idle_if_id_flush", 32'(if_id_flush), 32'd0);

        // Forwarding
        wb_rd_addr = 5'd3; wb_rd_we = 1; ex_rb_addr = 5'd5;
        #1;
        chk("fw_ra_ex_mem", 32'(ra_sel), 32'(FW_SEL_EX_MEM));
        chk("fw_rb_none", 32'(rb_sel), 32'(FW_SEL_NONE));
        mem_rd_we = 0;
        #1;
        chk("fw_ra_mem_wb", 32'(ra_sel), 32'(FW_SEL_MEM_WB));
        ex_ra_addr = 5'd0; mem_rd_addr = 5'd0; mem_rd_we = 1; wb_rd_addr = 5'd0;
        #1;
        chk("fw_ra_zero_reg", 32'(ra_sel), 32'(FW_SEL_NONE));
        ex_rb_addr = 5'd9; wb_rd_addr = 5'd9;
        #1;
        chk("fw_rb_mem_wb", 32'(rb_sel), 32'(FW_SEL_MEM_WB));
        mem_rd_we = 0; wb_rd_we = 0;

        // Load-use bubble
        ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 5'd7; id_rb_addr = 5'd7; id_rb_used = 1;
        #1;
        chk("lu_pc_stall", 32'(pc_stall), 32'd1);
        chk("lu_if_id_stall", 32'(if_id_stall), 32'd1);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("lu_if_id_flush", 32'(if_id_flush), 32'd0);
        chk("lu_id_ex_stall", 32'(id_ex_stall), 32'd0);
        tick();
        chk("lu_stall_cycles", stall_cycles, 32'd1);
        id_rb_used = 0;
        #1;
        chk("lu_unused_pc_stall", 32'(pc_stall), 32'd0);
        tick();
        chk("lu_unused_cycles", stall_cycles, 32'd1);

        // Branch beats load-use
        id_rb_used = 1; branch_req = 1;
        #1;
        chk("br_pc_load", 32'(pc_load_branch), 32'd1);
        chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("br_pc_stall", 32'(pc_stall), 32'd0);
        tick();
        chk("br_stall_cycles", stall_cycles, 32'd1);
        ex_is_load = 0; id_rb_used = 0;

        // Freeze 4 cycles with a branch held pending, then release
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("frz%0d_pc_stall", k), 32'(pc_stall), 32'd1);
            chk($sformatf("frz%0d_mem_wb_stall", k), 32'(mem_wb_stall), 32'd1);
            chk($sformatf("frz%0d_pc_load", k), 32'(pc_load_branch), 32'd0);
            tick();
        end
        mem_ready = 1;
        #1;
        chk("rel_pc_stall", 32'(pc_stall), 32'd0);
        chk("rel_ex_mem_stall", 32'(ex_mem_stall), 32'd0);
        chk("rel_pc_load", 32'(pc_load_branch), 32'd1);
        chk("rel_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("frz_stall_cycles", stall_cycles, 32'd5);
        tick();
        chk("rel_stall_cycles", stall_cycles, 32'd5);
        branch_req = 0;

        // Watchdog: 10 wait cycles with MEM_TIMEOUT=8
        mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("wd%0d_mem_timeout", k), 32'(mem_timeout), (k >= 8) ? 32'd1 : 32'd0);
        end
        mem_ready = 1;
        tick();
        chk("wd_sticky", 32'(mem_timeout), 32'd1);
        chk("wd_stall_cycles", stall_cycles, 32'd15);
        mem_req = 0; mem_ready = 0;
        tick();
        chk("wd_sticky_idle", 32'(mem_timeout), 32'd1);

        // Reset in the middle of a wait
        mem_req = 1;
        tick();
        tick();
        chk("rw_stall_cycles", stall_cycles, 32'd17);
        rst = 1;
        #1;
        chk("rw_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("rw_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("rw_pc_stall", 32'(pc_stall), 32'd0);
        tick();
        chk("rw_cycles_zero", stall_cycles, 32'd0);
        chk("rw_timeout_zero", 32'(mem_timeout), 32'd0);
        rst = 0; mem_req = 0;
        tick();
        // A fresh wait must need the full 8 cycles again
        mem_req = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("rw_wd%0d", k), 32'(mem_timeout), (k >= 8) ? 32'd1 : 32'd0);
        end
        chk("rw_final_cycles", stall_cycles, 32'd8);
        mem_req = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global bound in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout_guard got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
